// File: rtl/fp_to_fixed.sv
// Two-stage floating-point to signed fixed-point converter with programmable rounding,
// saturation and a saturating count of clamped/NaN results.
module fp_to_fixed #(
   parameter int unsigned C_EXP     = 5,
   parameter int unsigned C_MANT    = 10,
   parameter int unsigned C_BIAS    = 15,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned FRAC_BITS = 8,
   parameter logic [2:0]  RM_SI     = 3'b000,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [C_EXP+C_MANT:0]     in_data_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [OUT_WIDTH-1:0]      out_data_o,
   output logic                      out_sat_o,
   output logic                      out_nan_o,
   output logic [CNT_WIDTH-1:0]      sat_count_o,
   input  logic                      cnt_clear_i
);

   localparam int unsigned MW = C_MANT + 1;
   localparam int unsigned WW = MW + OUT_WIDTH;
   localparam int unsigned SW = C_EXP + 8;
   localparam int ShiftOff = int'(C_BIAS) + int'(C_MANT) - int'(FRAC_BITS);

   localparam logic [2:0] RmNearest  = 3'b000;
   localparam logic [2:0] RmTrunc    = 3'b001;
   localparam logic [2:0] RmMinusInf = 3'b010;
   localparam logic [2:0] RmPlusInf  = 3'b011;

   localparam logic [SW-1:0]        OutW   = SW'(OUT_WIDTH);
   localparam logic [SW-1:0]        MantW  = SW'(MW);
   localparam logic [WW:0]          PosLim = ((WW+1)'(1) << (OUT_WIDTH - 1)) - 1'b1;
   localparam logic [WW:0]          NegLim = (WW+1)'(1) << (OUT_WIDTH - 1);
   localparam logic [OUT_WIDTH-1:0] MaxVal = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0] MinVal = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   // Handshake: each stage loads when empty or when its content leaves this cycle
   logic s1_valid_q, s2_ready, s1_ready;
   assign s2_ready   = ~out_valid_o | out_ready_i;
   assign s1_ready   = ~s1_valid_q | s2_ready;
   assign in_ready_o = s1_ready;

   // Stage 1: unpack
   logic [C_EXP-1:0]      exp_f, e_eff;
   logic [C_MANT-1:0]     mant_f;
   logic                  exp_zero, exp_ones;
   logic signed [SW-1:0]  shift_d;

   always_comb begin
      exp_f    = in_data_i[C_EXP+C_MANT-1:C_MANT];
      mant_f   = in_data_i[C_MANT-1:0];
      exp_zero = (exp_f == '0);
      exp_ones = &exp_f;
      e_eff    = exp_zero ? C_EXP'(1) : exp_f;
      shift_d  = $signed(SW'(e_eff)) - $signed(SW'(ShiftOff));
   end

   logic                 s1_sign_q, s1_zero_q, s1_inf_q, s1_nan_q;
   logic [MW-1:0]        s1_mant_q;
   logic signed [SW-1:0] s1_shift_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_zero_q  <= 1'b0;
         s1_inf_q   <= 1'b0;
         s1_nan_q   <= 1'b0;
         s1_mant_q  <= '0;
         s1_shift_q <= '0;
      end else if (s1_ready) begin
         s1_valid_q <= in_valid_i;
         if (in_valid_i) begin
            s1_sign_q  <= in_data_i[C_EXP+C_MANT];
            s1_zero_q  <= exp_zero & (mant_f == '0);
            s1_inf_q   <= exp_ones & (mant_f == '0);
            s1_nan_q   <= exp_ones & (mant_f != '0);
            s1_mant_q  <= {~exp_zero, mant_f};
            s1_shift_q <= shift_d;
         end
      end
   end

   // Stage 2: align, round, apply sign, saturate
   logic [WW-1:0]        mag;
   logic [2*MW-1:0]      ext;
   logic [SW-1:0]        rsh;
   logic                 guard, sticky, ovf, inc;
   logic [WW:0]          rnd, neg;
   logic [OUT_WIDTH-1:0] data_d;
   logic                 sat_d, nan_d;

   always_comb begin
      mag    = '0;
      ext    = '0;
      rsh    = '0;
      guard  = 1'b0;
      sticky = 1'b0;
      ovf    = 1'b0;
      if (!s1_shift_q[SW-1]) begin
         if (s1_shift_q >= OutW) ovf = 1'b1;
         else mag = WW'(s1_mant_q) << s1_shift_q;
      end else begin
         rsh = -s1_shift_q;
         // Shifts past the whole significand leave only sticky information
         if (rsh > MantW) begin
            sticky = |s1_mant_q;
         end else begin
            ext    = {s1_mant_q, {MW{1'b0}}} >> rsh;
            mag    = WW'(ext[2*MW-1:MW]);
            guard  = ext[MW-1];
            sticky = |ext[MW-2:0];
         end
      end

      case (RM_SI)
         RmNearest:  inc = guard & (sticky | mag[0]);
         RmTrunc:    inc = 1'b0;
         RmPlusInf:  inc = (guard | sticky) & ~s1_sign_q;
         RmMinusInf: inc = (guard | sticky) & s1_sign_q;
         default:    inc = 1'b0;
      endcase

      rnd    = {1'b0, mag} + (WW+1)'(inc);
      neg    = ~rnd + 1'b1;
      data_d = '0;
      sat_d  = 1'b0;
      nan_d  = 1'b0;
      if (s1_nan_q) begin
         nan_d = 1'b1;
      end else if (s1_inf_q) begin
         sat_d  = 1'b1;
         data_d = s1_sign_q ? MinVal : MaxVal;
      end else if (s1_zero_q) begin
         data_d = '0;
      end else if (s1_sign_q) begin
         if (ovf || rnd > NegLim) begin
            sat_d  = 1'b1;
            data_d = MinVal;
         end else begin
            data_d = neg[OUT_WIDTH-1:0];
         end
      end else if (ovf || rnd > PosLim) begin
         sat_d  = 1'b1;
         data_d = MaxVal;
      end else begin
         data_d = rnd[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_sat_o   <= 1'b0;
         out_nan_o   <= 1'b0;
      end else if (s2_ready) begin
         out_valid_o <= s1_valid_q;
         if (s1_valid_q) begin
            out_data_o <= data_d;
            out_sat_o  <= sat_d;
            out_nan_o  <= nan_d;
         end
      end
   end

   // Flag counter: clear wins over a same-cycle increment
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sat_count_o <= '0;
      end else if (cnt_clear_i) begin
         sat_count_o <= '0;
      end else if (out_valid_o && out_ready_i && (out_sat_o || out_nan_o) && !(&sat_count_o)) begin
         sat_count_o <= sat_count_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_fp_to_fixed.sv
// Directed bench for fp_to_fixed: four instances (nearest, trunc, plus-inf, 4-bit counter)
// share one input stream; expected values are hand-computed constants and a small FIFO model.
module tb_fp_to_fixed;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready, cnt_clear;
   logic [15:0] in_data;

   logic        rdy_m, vld_m, sat_m, nan_m;
   logic [15:0] dat_m, cnt_m;
   logic        rdy_t, vld_t, sat_t, nan_t;
   logic [15:0] dat_t, cnt_t;
   logic        rdy_u, vld_u, sat_u, nan_u;
   logic [15:0] dat_u, cnt_u;
   logic        rdy_c, vld_c, sat_c, nan_c;
   logic [15:0] dat_c;
   logic [3:0]  cnt_c;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fp_to_fixed dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_m),
      .in_data_i(in_data), .out_valid_o(vld_m), .out_ready_i(out_ready),
      .out_data_o(dat_m), .out_sat_o(sat_m), .out_nan_o(nan_m),
      .sat_count_o(cnt_m), .cnt_clear_i(cnt_clear)
   );

   fp_to_fixed #(.RM_SI(3'b001)) dut_tz (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_t),
      .in_data_i(in_data), .out_valid_o(vld_t), .out_ready_i(out_ready),
      .out_data_o(dat_t), .out_sat_o(sat_t), .out_nan_o(nan_t),
      .sat_count_o(cnt_t), .cnt_clear_i(cnt_clear)
   );

   fp_to_fixed #(.RM_SI(3'b011)) dut_up (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_u),
      .in_data_i(in_data), .out_valid_o(vld_u), .out_ready_i(out_ready),
      .out_data_o(dat_u), .out_sat_o(sat_u), .out_nan_o(nan_u),
      .sat_count_o(cnt_u), .cnt_clear_i(cnt_clear)
   );

   fp_to_fixed #(.CNT_WIDTH(4)) dut_c4 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_c),
      .in_data_i(in_data), .out_valid_o(vld_c), .out_ready_i(out_ready),
      .out_data_o(dat_c), .out_sat_o(sat_c), .out_nan_o(nan_c),
      .sat_count_o(cnt_c), .cnt_clear_i(cnt_clear)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Called at a negedge; returns at the negedge where the result is on the outputs
   task automatic convert(input logic [15:0] x);
      in_valid = 1'b1;
      in_data  = x;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("latency_not_early", vld_m, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("latency_valid", vld_m, 1'b1);
   endtask

   logic [15:0] bp_in  [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                               16'h4500, 16'h4600, 16'h4700, 16'h4800};
   logic [15:0] bp_exp [8] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400,
                               16'h0500, 16'h0600, 16'h0700, 16'h0800};

   initial begin
      int          sent, got, occ;
      logic        stall_prev;
      logic [15:0] held;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clear = 1'b0;
      #12;
      chk("rst_valid", vld_m, 1'b0);
      chk("rst_data", dat_m, 16'h0000);
      chk("rst_sat", sat_m, 1'b0);
      chk("rst_nan", nan_m, 1'b0);
      chk("rst_count", cnt_m, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", rdy_m, 1'b1);

      convert(16'h3C00);
      chk("one_data", dat_m, 16'h0100);
      chk("one_sat", sat_m, 1'b0);
      chk("one_nan", nan_m, 1'b0);

      convert(16'hC100);
      chk("neg2p5_near", dat_m, 16'hFD80);
      chk("neg2p5_trunc", dat_t, 16'hFD80);
      chk("neg2p5_up", dat_u, 16'hFD80);

      convert(16'h1800);
      chk("tie_even_near", dat_m, 16'h0000);

      convert(16'h1E00);
      chk("1p5lsb_near", dat_m, 16'h0002);
      chk("1p5lsb_up", dat_u, 16'h0002);
      chk("1p5lsb_trunc", dat_t, 16'h0001);

      convert(16'h0001);
      chk("subnorm_up", dat_u, 16'h0001);
      chk("subnorm_near", dat_m, 16'h0000);
      chk("subnorm_trunc", dat_t, 16'h0000);

      convert(16'h7BFF);
      chk("max_data", dat_m, 16'h7FFF);
      chk("max_sat", sat_m, 1'b1);

      convert(16'hFC00);
      chk("neginf_data", dat_m, 16'h8000);
      chk("neginf_sat", sat_m, 1'b1);

      convert(16'hD800);
      chk("neg128_data", dat_m, 16'h8000);
      chk("neg128_sat", sat_m, 1'b0);

      convert(16'h7E00);
      chk("nan_data", dat_m, 16'h0000);
      chk("nan_flag", nan_m, 1'b1);
      chk("nan_sat", sat_m, 1'b0);

      @(posedge clk);
      @(negedge clk);
      chk("count_three", cnt_m, 16'd3);
      chk("count4_three", cnt_c, 4'd3);
      chk("drained", vld_m, 1'b0);

      for (int i = 0; i < 14; i++) convert(16'h7C00);
      @(posedge clk);
      @(negedge clk);
      chk("count4_hold", cnt_c, 4'hF);
      chk("count16_run", cnt_m, 16'd17);

      convert(16'h7C00);
      cnt_clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cnt_clear = 1'b0;
      chk("clear_prio", cnt_m, 16'd0);
      chk("clear_prio4", cnt_c, 4'd0);

      // Backpressure stream with out_ready pattern 1,0,0,1
      sent = 0; got = 0; occ = 0; stall_prev = 1'b0; held = '0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         @(negedge clk);
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         in_valid  = (sent < 8);
         in_data   = bp_in[(sent < 8) ? sent : 0];
         #1;
         if (stall_prev) chk("bp_hold", dat_m, held);
         chk("bp_in_ready", rdy_m, !(occ == 2 && !out_ready));
         if (vld_m && out_ready) begin
            chk("bp_data", dat_m, bp_exp[got]);
            got++;
            occ--;
         end
         if (in_valid && rdy_m) begin
            sent++;
            occ++;
         end
         stall_prev = vld_m && !out_ready;
         held       = dat_m;
      end
      chk("bp_delivered", got, 8);
      chk("bp_sent", sent, 8);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_no_dup", vld_m, 1'b0);

      // Fill both stages, then reset asynchronously between edges
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h4000;
      @(posedge clk);
      @(negedge clk);
      in_data = 16'h4200;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("full_valid", vld_m, 1'b1);
      chk("full_in_ready", rdy_m, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", vld_m, 1'b0);
      chk("async_rst_data", dat_m, 16'h0000);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      convert(16'h4400);
      chk("post_rst_data", dat_m, 16'h0400);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
